// File: rtl/spi_ram_arbiter_if.sv
// Signal bundle between the SPI/RAM arbiter, its SPI slave, the local host and the RAM.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface spi_ram_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic [9:0]           rx_data;
  logic                 rx_valid;
  logic [9:0]           tx_data;
  logic                 tx_valid;
  logic                 spi_drop;
  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [7:0]           host_wdata;
  logic                 host_gnt;
  logic [7:0]           host_rdata;
  logic                 host_rvalid;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [7:0]           ram_din;
  logic [7:0]           ram_dout;

  modport slave (
    input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_dout,
    output tx_data, tx_valid, spi_drop, host_gnt, host_rdata, host_rvalid,
           ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_dout,
    input  tx_data, tx_valid, spi_drop, host_gnt, host_rdata, host_rvalid,
           ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between SPI command frames and a local host,
// round-robin on ties, with a one-deep SPI request slot.
module spi_ram_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_ram_arbiter_if.slave   bus
);

  if (MEM_DEPTH > (1 << ADDR_SIZE)) begin : g_depth_check
    $error("spi_ram_arbiter: MEM_DEPTH does not fit in ADDR_SIZE address bits");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {GNT_HOST, GNT_SPI} grant_t;
  typedef enum logic [1:0] {
    CMD_LOAD_WR = 2'b00,
    CMD_WRITE   = 2'b01,
    CMD_LOAD_RD = 2'b10,
    CMD_READ    = 2'b11
  } cmd_t;

  state_t               state;
  grant_t               last_grant;
  grant_t               winner;
  logic                 slot_full;
  logic                 slot_we;
  logic [ADDR_SIZE-1:0] slot_addr;
  logic [7:0]           slot_data;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  cmd_t rx_cmd;
  logic rx_access;
  logic slot_grant;
  logic spi_wins;

  assign rx_cmd     = cmd_t'(bus.rx_data[9:8]);
  assign rx_access  = bus.rx_valid && rx_cmd[0];
  // The slot frees in the very cycle it is presented to the RAM, so a new
  // access command arriving then takes its place instead of being dropped.
  assign slot_grant = (state == ACCESS) && (winner == GNT_SPI);
  assign spi_wins   = slot_full && (!bus.host_req || last_grant == GNT_HOST);

  // NOTE: all state below uses non-blocking assignments so every register sees
  // the pre-edge value of every other register, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= GNT_HOST;
      winner          <= GNT_HOST;
      slot_full       <= 1'b0;
      slot_we         <= 1'b0;
      slot_addr       <= '0;
      slot_data       <= '0;
      wr_addr         <= '0;
      rd_addr         <= '0;
      bus.tx_data     <= '0;
      bus.tx_valid    <= 1'b0;
      bus.spi_drop    <= 1'b0;
      bus.host_gnt    <= 1'b0;
      bus.host_rdata  <= '0;
      bus.host_rvalid <= 1'b0;
      bus.ram_en      <= 1'b0;
      bus.ram_we      <= 1'b0;
      bus.ram_addr    <= '0;
      bus.ram_din     <= '0;
    end else begin
      bus.tx_valid    <= 1'b0;
      bus.host_rvalid <= 1'b0;
      bus.spi_drop    <= 1'b0;

      if (bus.rx_valid && rx_cmd == CMD_LOAD_WR) wr_addr <= bus.rx_data[ADDR_SIZE-1:0];
      if (bus.rx_valid && rx_cmd == CMD_LOAD_RD) rd_addr <= bus.rx_data[ADDR_SIZE-1:0];

      if (slot_grant) slot_full <= 1'b0;
      if (rx_access) begin
        if (slot_full && !slot_grant) begin
          bus.spi_drop <= 1'b1;
        end else begin
          slot_full <= 1'b1;
          slot_we   <= (rx_cmd == CMD_WRITE);
          slot_addr <= (rx_cmd == CMD_WRITE) ? wr_addr : rd_addr;
          slot_data <= bus.rx_data[7:0];
        end
      end

      unique case (state)
        IDLE: begin
          if (slot_full || bus.host_req) begin
            state      <= ACCESS;
            bus.ram_en <= 1'b1;
            if (spi_wins) begin
              winner       <= GNT_SPI;
              last_grant   <= GNT_SPI;
              bus.ram_we   <= slot_we;
              bus.ram_addr <= slot_addr;
              bus.ram_din  <= slot_data;
            end else begin
              winner       <= GNT_HOST;
              last_grant   <= GNT_HOST;
              bus.ram_we   <= bus.host_we;
              bus.ram_addr <= bus.host_addr;
              bus.ram_din  <= bus.host_wdata;
              bus.host_gnt <= 1'b1;
            end
          end
        end
        ACCESS: begin
          bus.ram_en   <= 1'b0;
          bus.ram_we   <= 1'b0;
          bus.host_gnt <= 1'b0;
          state        <= bus.ram_we ? IDLE : RESP;
        end
        RESP: begin
          if (winner == GNT_SPI) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= {2'b00, bus.ram_dout};
          end else begin
            bus.host_rvalid <= 1'b1;
            bus.host_rdata  <= bus.ram_dout;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, RAM word count.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, RAM address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data  input  10  SPI slave frame; [9:8] command, [7:0] payload.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port tx_data  output  10  read response to SPI slave, {2'b00, byte}.
REQ-008 SHALL have port tx_valid  output  1  one-cycle strobe qualifying tx_data.
REQ-009 SHALL have port spi_drop  output  1  one-cycle pulse: SPI access command discarded.
REQ-010 SHALL have ports host_req/host_we  input  1 each  local host request, write-enable.
REQ-011 SHALL have ports host_addr  input  ADDR_SIZE, host_wdata  input  8  host address/data.
REQ-012 SHALL have ports host_gnt  output  1, host_rdata  output  8, host_rvalid  output  1.
REQ-013 SHALL have ports ram_en, ram_we  output  1 each; ram_addr  output  ADDR_SIZE; ram_din  output  8.
REQ-014 SHALL have port ram_dout  input  8  RAM read data, valid one cycle after ram_en with ram_we=0.

Function
REQ-015 SHALL decode rx_data[9:8] on rx_valid: 00 load wr_addr, 01 SPI write request, 10 load rd_addr, 11 SPI read request.
REQ-016 SHALL update wr_addr/rd_addr from rx_data[ADDR_SIZE-1:0] the cycle after 00/10, regardless of state.
REQ-017 SHALL hold one SPI pending slot; 01 snapshots {write, wr_addr, rx_data[7:0]}, 11 snapshots {read, rd_addr}.
REQ-018 SHALL, on 01/11 while slot full and not being granted that cycle, discard the new command and pulse spi_drop.
REQ-019 SHALL accept a 01/11 arriving in the same cycle the slot is granted, with no spi_drop.
REQ-020 SHALL use address as updated before the 01/11 cycle (00 then 01 back-to-back uses new address).
REQ-021 SHALL implement FSM IDLE, ACCESS, RESP; reset state IDLE.
REQ-022 IDLE: if any request pending -> ACCESS; else stay.
REQ-023 SHALL arbitrate round-robin in IDLE: single requester wins; both -> requester not granted last; last_grant resets to HOST (SPI wins first tie).
REQ-024 ACCESS: ram_en=1, ram_we/ram_addr/ram_din from winner for exactly one cycle; host winner gets host_gnt=1 this cycle; SPI slot cleared this cycle.
REQ-025 ACCESS -> RESP if read, -> IDLE if write.
REQ-026 RESP: capture ram_dout; SPI read -> tx_valid=1, tx_data={2'b00,ram_dout} for one cycle; host read -> host_rvalid=1, host_rdata=ram_dout; then -> IDLE.
REQ-027 SHALL hold tx_data and host_rdata stable between responses.
REQ-028 Host SHALL hold host_req/host_we/host_addr/host_wdata stable until host_gnt; block samples them only in ACCESS.
REQ-029 Latency: write 2 cycles request-to-ram_en (IDLE, ACCESS); read 3 cycles request-to-valid strobe.
REQ-030 SHALL drive ram_en=0, ram_we=0 outside ACCESS.

Reset
REQ-031 On rst_n=0, immediately and asynchronously: state IDLE, slot empty, wr_addr=rd_addr=0, last_grant=HOST.
REQ-032 On rst_n=0: tx_data=0, tx_valid=0, spi_drop=0, host_gnt=0, host_rdata=0, host_rvalid=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
REQ-033 Reset mid-ACCESS/RESP SHALL abandon the transaction; no strobe issued after release.

Verification
REQ-034 SPI frames 0x005, 0x1A5, 0x205, 0x300 -> ram write addr 0x05 data 0xA5; then tx_valid with tx_data=0x0A5.
REQ-035 host_req=1,we=1,addr 0x10,wdata 0x3C held; then read 0x10 -> host_gnt each access, host_rvalid with host_rdata=0x3C.
REQ-036 SPI read request and host_req asserted same cycle after reset -> SPI granted first, host next; alternate on repeated ties.
REQ-037 Two 01 frames while slot pending and host occupying ACCESS -> second frame dropped, spi_drop pulses once, only first write reaches RAM.
REQ-038 rst_n low during RESP of SPI read -> no tx_valid pulse; all outputs zero; next 0x300 works normally with rd_addr=0.
